// File: rtl/cardinal_dmem_responder.sv
// Data-memory responder for the cardinal pipeline.
// After reset a scrub pass zeroes every word, and then loads and stores are served.
// The processor numbers its bits big-endian [0:63]. Its bit 0 is the MSB, which is
// bit DATA_W-1 here. Vectors are declared descending, so values connect unchanged.
module cardinal_dmem_responder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Mem_Addr,
    input  logic [DATA_W-1:0] Data_In,
    input  logic              DmemEn,
    input  logic              DmemWrEn,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Ready,
    output logic              Req_Err,
    output logic [15:0]       Load_Cnt,
    output logic [15:0]       Store_Cnt
);

    typedef enum logic {
        SCRUB = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [15:0]       CNT_MAX   = 16'hFFFF;

    state_t            state;
    logic [ADDR_W-1:0] scrub_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array: the scrub pass owns the write port until the FSM reaches READY
    always_ff @(posedge Clock) begin
        if (state == SCRUB) begin
            mem[scrub_ptr] <= '0;
        end else if (DmemEn && DmemWrEn) begin
            mem[Mem_Addr] <= Data_In;
        end
    end

    // Scrub/ready FSM with registered load data, status flags and saturating counters
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= SCRUB;
            scrub_ptr <= '0;
            Data_Out  <= '0;
            Ready     <= 1'b0;
            Req_Err   <= 1'b0;
            Load_Cnt  <= '0;
            Store_Cnt <= '0;
        end else begin
            case (state)
                SCRUB: begin
                    scrub_ptr <= scrub_ptr + 1'b1;
                    if (scrub_ptr == LAST_ADDR) begin
                        state <= READY;
                        Ready <= 1'b1;
                    end
                    if (DmemEn) begin
                        Req_Err <= 1'b1;
                    end
                end
                READY: begin
                    if (DmemEn) begin
                        if (DmemWrEn) begin
                            if (Store_Cnt != CNT_MAX) begin
                                Store_Cnt <= Store_Cnt + 16'd1;
                            end
                        end else begin
                            Data_Out <= mem[Mem_Addr];
                            if (Load_Cnt != CNT_MAX) begin
                                Load_Cnt <= Load_Cnt + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    state <= SCRUB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cardinal_dmem_responder.sv
// Self-checking bench for cardinal_dmem_responder: table-driven vectors plus
// hand-written sequences for scrub timing, reset mid-operation and counter saturation.
module tb_cardinal_dmem_responder;

    logic        Clock;
    logic        Reset;
    logic [7:0]  Mem_Addr;
    logic [63:0] Data_In;
    logic        DmemEn;
    logic        DmemWrEn;
    logic [63:0] Data_Out;
    logic        Ready;
    logic        Req_Err;
    logic [15:0] Load_Cnt;
    logic [15:0] Store_Cnt;

    int total_cnt = 0;
    int bad_cnt   = 0;

    typedef struct {
        logic        en;
        logic        wr;
        logic [7:0]  addr;
        logic [63:0] din;
        logic [63:0] exp_dout;
        logic [15:0] exp_loads;
        logic [15:0] exp_stores;
    } vec_t;

    vec_t vecs [16];

    cardinal_dmem_responder #(
        .DEPTH (256),
        .ADDR_W(8),
        .DATA_W(64)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Mem_Addr (Mem_Addr),
        .Data_In  (Data_In),
        .DmemEn   (DmemEn),
        .DmemWrEn (DmemWrEn),
        .Data_Out (Data_Out),
        .Ready    (Ready),
        .Req_Err  (Req_Err),
        .Load_Cnt (Load_Cnt),
        .Store_Cnt(Store_Cnt)
    );

    // Free-running clock, 10 time units per period
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Drive one request, then wait until the following falling edge
    task automatic apply_stimulus(input logic en, input logic wr,
                                  input logic [7:0] addr, input logic [63:0] din);
        DmemEn   = en;
        DmemWrEn = wr;
        Mem_Addr = addr;
        Data_In  = din;
        @(negedge Clock);
    endtask

    task automatic check_output(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Idle through the scrub pass, checking Ready just before and just after it completes
    task automatic run_scrub(input string tag, input bit inject_early);
        for (int c = 1; c <= 256; c++) begin
            if (inject_early && c == 11) begin
                apply_stimulus(1'b1, 1'b1, 8'h10, 64'hDEAD_BEEF_0000_0001);
                check_output({tag, " early req_err"}, 64'(Req_Err), 64'd1);
                check_output({tag, " early store_cnt"}, 64'(Store_Cnt), 64'd0);
                check_output({tag, " early ready"}, 64'(Ready), 64'd0);
            end else begin
                apply_stimulus(1'b0, 1'b0, 8'h00, 64'h0);
            end
            if (c == 255) check_output({tag, " ready@255"}, 64'(Ready), 64'd0);
            if (c == 256) check_output({tag, " ready@256"}, 64'(Ready), 64'd1);
        end
    endtask

    initial begin
        // Vectors start right after the first scrub; counters are cumulative
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 64'h0, 64'h0, 16'd1, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'h7F, 64'h0, 64'h0, 16'd2, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 8'hFF, 64'h0, 64'h0, 16'd3, 16'd0};
        vecs[3]  = '{1'b1, 1'b0, 8'h10, 64'h0, 64'h0, 16'd4, 16'd0};
        vecs[4]  = '{1'b1, 1'b1, 8'h05, 64'h0123_4567_89AB_CDEF, 64'h0, 16'd4, 16'd1};
        vecs[5]  = '{1'b1, 1'b0, 8'h05, 64'h0, 64'h0123_4567_89AB_CDEF, 16'd5, 16'd1};
        vecs[6]  = '{1'b1, 1'b0, 8'h05, 64'h0, 64'h0123_4567_89AB_CDEF, 16'd6, 16'd1};
        vecs[7]  = '{1'b0, 1'b0, 8'h05, 64'h0, 64'h0123_4567_89AB_CDEF, 16'd6, 16'd1};
        vecs[8]  = '{1'b0, 1'bx, 8'h06, 64'h0, 64'h0123_4567_89AB_CDEF, 16'd6, 16'd1};
        vecs[9]  = '{1'b0, 1'b1, 8'h06, 64'h0, 64'h0123_4567_89AB_CDEF, 16'd6, 16'd1};
        vecs[10] = '{1'b1, 1'b1, 8'h06, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0123_4567_89AB_CDEF, 16'd6, 16'd2};
        vecs[11] = '{1'b1, 1'b0, 8'h06, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA, 16'd7, 16'd2};
        vecs[12] = '{1'b1, 1'b1, 8'h06, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 16'd7, 16'd3};
        vecs[13] = '{1'b1, 1'b0, 8'h06, 64'h0, 64'h5555_5555_5555_5555, 16'd8, 16'd3};
        vecs[14] = '{1'b1, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555, 16'd8, 16'd4};
        vecs[15] = '{1'b1, 1'b0, 8'hFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 16'd9, 16'd4};

        Reset    = 1'b0;
        DmemEn   = 1'b0;
        DmemWrEn = 1'b0;
        Mem_Addr = 8'h00;
        Data_In  = 64'h0;
        #2;
        check_output("reset data_out", Data_Out, 64'h0);
        check_output("reset ready", 64'(Ready), 64'd0);
        check_output("reset req_err", 64'(Req_Err), 64'd0);
        check_output("reset load_cnt", 64'(Load_Cnt), 64'd0);
        check_output("reset store_cnt", 64'(Store_Cnt), 64'd0);

        @(negedge Clock);
        Reset = 1'b1;
        run_scrub("scrub1", 1'b1);

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din);
            check_output($sformatf("vec%0d data_out", i), Data_Out, vecs[i].exp_dout);
            check_output($sformatf("vec%0d load_cnt", i), 64'(Load_Cnt), 64'(vecs[i].exp_loads));
            check_output($sformatf("vec%0d store_cnt", i), 64'(Store_Cnt), 64'(vecs[i].exp_stores));
        end
        check_output("req_err sticky", 64'(Req_Err), 64'd1);

        // Reset mid-operation: outputs clear immediately, then a fresh scrub runs
        DmemEn = 1'b0;
        Reset  = 1'b0;
        #1;
        check_output("midreset ready", 64'(Ready), 64'd0);
        check_output("midreset data_out", Data_Out, 64'h0);
        check_output("midreset req_err", 64'(Req_Err), 64'd0);
        check_output("midreset load_cnt", 64'(Load_Cnt), 64'd0);
        check_output("midreset store_cnt", 64'(Store_Cnt), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        run_scrub("scrub2", 1'b0);
        check_output("after scrub2 req_err", 64'(Req_Err), 64'd0);
        apply_stimulus(1'b1, 1'b0, 8'hFF, 64'h0);
        check_output("rescrubbed 0xFF", Data_Out, 64'h0);
        check_output("rescrub load_cnt", 64'(Load_Cnt), 64'd1);
        check_output("rescrub store_cnt", 64'(Store_Cnt), 64'd0);

        // Saturation: push the load counter past its limit
        for (int n = 2; n <= 65540; n++) begin
            apply_stimulus(1'b1, 1'b0, 8'h00, 64'h0);
            if (n == 65534) check_output("load_cnt 65534", 64'(Load_Cnt), 64'hFFFE);
            if (n == 65535) check_output("load_cnt 65535", 64'(Load_Cnt), 64'hFFFF);
        end
        check_output("load_cnt saturated", 64'(Load_Cnt), 64'hFFFF);
        check_output("sat store_cnt", 64'(Store_Cnt), 64'd0);
        apply_stimulus(1'b0, 1'b0, 8'h00, 64'h0);
        check_output("load_cnt held", 64'(Load_Cnt), 64'hFFFF);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
